l1mtx_arb_rr: RTL and testbench



---
 rtl/l1mtx_pkg.sv | 39 +++
 rtl/l1mtx_burst_cnt.sv | 49 ++++
 rtl/l1mtx_arb_rr.sv | 88 ++++++++
 tb/tb_l1mtx_arb_rr.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/l1mtx_pkg.sv
// Shared encodings and burst-length helper for the L1 bus-matrix output-stage arbiter.
// No logic or latency; constants and a pure function only.
// No flow control of its own.
package l1mtx_pkg;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        BU_SINGLE = 3'b000,
        BU_INCR   = 3'b001,
        BU_WRAP4  = 3'b010,
        BU_INCR4  = 3'b011,
        BU_WRAP8  = 3'b100,
        BU_INCR8  = 3'b101,
        BU_WRAP16 = 3'b110,
        BU_INCR16 = 3'b111
    } hburst_e;

    localparam logic [1:0] PORT2 = 2'b10;
    localparam logic [1:0] PORT3 = 2'b11;

    // Undefined-length INCR is arbitrated like a single beat.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        logic [4:0] n;
        case (hburst)
            BU_WRAP4,  BU_INCR4:  n = 5'd4;
            BU_WRAP8,  BU_INCR8:  n = 5'd8;
            BU_WRAP16, BU_INCR16: n = 5'd16;
            default:              n = 5'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/l1mtx_burst_cnt.sv
// Beat counter that keeps the grant for the full length of a fixed-length burst.
// burst_hold is combinational from the current transfer and the registered count.
// State advances only when HREADYM=1; with HREADYM low the count holds.
module l1mtx_burst_cnt
    import l1mtx_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HREADYM,
    input  logic       HSELM,
    input  logic [1:0] HTRANSM,
    input  logic [2:0] HBURSTM,
    output logic       burst_hold
);

    logic [4:0] beats_left_q;
    logic [4:0] beats_left_d;
    logic [4:0] beats_cur;

    // beats_cur = beats of the burst still to go, counting the one on the bus now.
    always_comb begin
        beats_cur = 5'd0;
        if (HTRANSM == TR_NONSEQ) begin
            beats_cur = burst_beats(HBURSTM);
        end else if (beats_left_q != 5'd0) begin
            beats_cur = beats_left_q - 5'd1;
        end

        beats_left_d = beats_left_q;
        if (HREADYM) begin
            if (!HSELM || (HTRANSM == TR_IDLE)) begin
                beats_left_d = 5'd0;
            end else if (HTRANSM != TR_BUSY) begin
                beats_left_d = beats_cur;
            end
        end
    end

    assign burst_hold = HSELM && HTRANSM[1] && (beats_cur > 5'd1);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            beats_left_q <= 5'd0;
        end else begin
            beats_left_q <= beats_left_d;
        end
    end

endmodule

// File: rtl/l1mtx_arb_rr.sv
// Round-robin grant of the shared slave address phase between ports 2 and 3; L1MTX_FIXED_BURST_HOLD_EN adds burst hold.
// Latency: one HCLK edge from request to registered addr_in_port/no_port.
// HREADYM low freezes all state; lock, BUSY (and counted bursts) hold the grant.
module l1mtx_arb_rr
    import l1mtx_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       req_port2,
    input  logic       req_port3,
    input  logic       HREADYM,
    input  logic       HSELM,
    input  logic [1:0] HTRANSM,
    input  logic [2:0] HBURSTM,
    input  logic       HMASTLOCKM,
    output logic [1:0] addr_in_port,
    output logic       no_port
);

    logic [1:0] addr_in_port_q, addr_in_port_d;
    logic       no_port_q, no_port_d;
    logic       last_grant_q, last_grant_d;
    logic       burst_hold;
    logic       hold;

`ifdef L1MTX_FIXED_BURST_HOLD_EN
    l1mtx_burst_cnt u_burst_cnt (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HREADYM    (HREADYM),
        .HSELM      (HSELM),
        .HTRANSM    (HTRANSM),
        .HBURSTM    (HBURSTM),
        .burst_hold (burst_hold)
    );
`else
    logic unused_hburst;
    assign unused_hburst = ^HBURSTM;
    assign burst_hold    = 1'b0;
`endif

    assign hold = HMASTLOCKM || (HSELM && (HTRANSM == TR_BUSY)) || burst_hold;

    always_comb begin
        addr_in_port_d = addr_in_port_q;
        no_port_d      = no_port_q;
        last_grant_d   = last_grant_q;
        if (HREADYM && !hold) begin
            case ({req_port2, req_port3})
                2'b10: begin
                    addr_in_port_d = PORT2;
                    no_port_d      = 1'b0;
                    last_grant_d   = 1'b0;
                end
                2'b01: begin
                    addr_in_port_d = PORT3;
                    no_port_d      = 1'b0;
                    last_grant_d   = 1'b1;
                end
                2'b11: begin
                    addr_in_port_d = last_grant_q ? PORT2 : PORT3;
                    no_port_d      = 1'b0;
                    last_grant_d   = ~last_grant_q;
                end
                default: begin
                    // Park on the last port so the address mux select stays stable.
                    no_port_d      = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_in_port_q <= PORT2;
            no_port_q      <= 1'b1;
            last_grant_q   <= 1'b1;
        end else begin
            addr_in_port_q <= addr_in_port_d;
            no_port_q      <= no_port_d;
            last_grant_q   <= last_grant_d;
        end
    end

    assign addr_in_port = addr_in_port_q;
    assign no_port      = no_port_q;

endmodule

// File: tb/tb_l1mtx_arb_rr.sv
// Bench for l1mtx_arb_rr: directed scenarios with literal expectations plus random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_l1mtx_arb_rr;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic       req_port2 = 1'b0;
    logic       req_port3 = 1'b0;
    logic       HREADYM = 1'b0;
    logic       HSELM = 1'b0;
    logic [1:0] HTRANSM = 2'b00;
    logic [2:0] HBURSTM = 3'b000;
    logic       HMASTLOCKM = 1'b0;
    logic [1:0] addr_in_port;
    logic       no_port;

    int vectors = 0;
    int miscompares = 0;

    l1mtx_arb_rr dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .req_port2    (req_port2),
        .req_port3    (req_port3),
        .HREADYM      (HREADYM),
        .HSELM        (HSELM),
        .HTRANSM      (HTRANSM),
        .HBURSTM      (HBURSTM),
        .HMASTLOCKM   (HMASTLOCKM),
        .addr_in_port (addr_in_port),
        .no_port      (no_port)
    );

    always #5 HCLK = ~HCLK;

    // Reference model: which port is granted, whether idle, who was served last,
    // and position within the current burst (beat number vs. total beats).
    logic [1:0] m_port;
    logic       m_nop;
    logic       m_last;
    int         m_beat;
    int         m_total;

    function automatic int burst_len(input logic [2:0] b);
        if (b <= 3'd1) return 1;
        if (b <= 3'd3) return 4;
        if (b <= 3'd5) return 8;
        return 16;
    endfunction

    always @(posedge HCLK or negedge HRESETn) begin
        int  beat, total;
        bit  hold;
        if (!HRESETn) begin
            m_port  <= 2'b10;
            m_nop   <= 1'b1;
            m_last  <= 1'b1;
            m_beat  <= 0;
            m_total <= 0;
        end else if (HREADYM) begin
            beat  = m_beat;
            total = m_total;
            if (!HSELM || HTRANSM == 2'b00) begin
                beat  = 0;
                total = 0;
            end else if (HTRANSM == 2'b10) begin
                beat  = 1;
                total = burst_len(HBURSTM);
            end else if (HTRANSM == 2'b11) begin
                beat = beat + 1;
            end
            hold = HMASTLOCKM || (HSELM && HTRANSM == 2'b01);
`ifdef L1MTX_FIXED_BURST_HOLD_EN
            if (HSELM && HTRANSM[1] && beat < total) hold = 1'b1;
`endif
            if (!hold) begin
                if (req_port2 && req_port3) begin
                    m_port <= m_last ? 2'b10 : 2'b11;
                    m_last <= !m_last;
                    m_nop  <= 1'b0;
                end else if (req_port2) begin
                    m_port <= 2'b10;
                    m_last <= 1'b0;
                    m_nop  <= 1'b0;
                end else if (req_port3) begin
                    m_port <= 2'b11;
                    m_last <= 1'b1;
                    m_nop  <= 1'b0;
                end else begin
                    m_nop  <= 1'b1;
                end
            end
            m_beat  <= (beat > 64) ? 64 : beat;
            m_total <= total;
        end
    end

    always @(negedge HCLK) begin
        vectors++;
        if ({addr_in_port, no_port} !== {m_port, m_nop}) begin
            miscompares++;
            $display("FAIL model_cmp t=%0t: got port=%b no_port=%b expected port=%b no_port=%b",
                     $time, addr_in_port, no_port, m_port, m_nop);
        end
    end

    task automatic chk(input string nm, input logic [2:0] exp);
        vectors++;
        if ({addr_in_port, no_port} !== exp) begin
            miscompares++;
            $display("FAIL %s: got {port,no_port}=%b expected %b", nm, {addr_in_port, no_port}, exp);
        end
        vectors++;
        if ({m_port, m_nop} !== exp) begin
            miscompares++;
            $display("FAIL model_%s: got {port,no_port}=%b expected %b", nm, {m_port, m_nop}, exp);
        end
    endtask

    task automatic drive(input bit r2, input bit r3, input bit rdy, input bit sel,
                         input bit [1:0] tr, input bit [2:0] bu, input bit lk);
        req_port2  = r2;
        req_port3  = r3;
        HREADYM    = rdy;
        HSELM      = sel;
        HTRANSM    = tr;
        HBURSTM    = bu;
        HMASTLOCKM = lk;
    endtask

    task automatic step;
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    task automatic do_reset;
        @(negedge HCLK);
        HRESETn = 1'b0;
        drive(0, 0, 0, 0, 2'b00, 3'b000, 0);
        @(negedge HCLK);
        chk("reset", 3'b101);
        HRESETn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single request from reset.
        do_reset();
        drive(1, 0, 1, 1, 2'b10, 3'b000, 0);
        step();
        chk("first_req", 3'b100);

        // Tie alternation, port 2 first.
        do_reset();
        drive(1, 1, 1, 1, 2'b10, 3'b000, 0);
        step(); chk("alt0", 3'b100);
        step(); chk("alt1", 3'b110);
        step(); chk("alt2", 3'b100);
        step(); chk("alt3", 3'b110);

        // Locked sequence on port 3, including an IDLE gap with the request dropped.
        do_reset();
        drive(0, 1, 1, 1, 2'b00, 3'b000, 0);
        step(); chk("lock_grant", 3'b110);
        drive(1, 1, 1, 1, 2'b10, 3'b000, 1); step(); chk("lock_c1", 3'b110);
        drive(1, 1, 1, 1, 2'b11, 3'b000, 1); step(); chk("lock_c2", 3'b110);
        drive(1, 0, 1, 1, 2'b00, 3'b000, 1); step(); chk("lock_idle1", 3'b110);
        drive(1, 0, 1, 1, 2'b00, 3'b000, 1); step(); chk("lock_idle2", 3'b110);
        drive(1, 1, 1, 1, 2'b10, 3'b000, 1); step(); chk("lock_c5", 3'b110);
        drive(1, 0, 1, 1, 2'b00, 3'b000, 0); step(); chk("lock_release", 3'b100);

        // INCR8 on port 2 with port 3 competing from the first beat.
        do_reset();
        drive(1, 0, 1, 1, 2'b00, 3'b000, 0);
        step(); chk("burst_pre", 3'b100);
        drive(1, 1, 1, 1, 2'b10, 3'b101, 0);
        step();
`ifdef L1MTX_FIXED_BURST_HOLD_EN
        chk("burst_b1", 3'b100);
        for (int b = 2; b <= 8; b++) begin
            drive(1, 1, 1, 1, 2'b11, 3'b101, 0);
            step();
            chk($sformatf("burst_b%0d", b), (b == 8) ? 3'b110 : 3'b100);
        end
`else
        chk("burst_b1", 3'b110);
        for (int b = 2; b <= 8; b++) begin
            drive(1, 1, 1, 1, 2'b11, 3'b101, 0);
            step();
        end
`endif

        // HREADYM low freezes the alternation.
        do_reset();
        drive(1, 1, 1, 1, 2'b10, 3'b000, 0);
        step(); chk("frz_start", 3'b100);
        drive(1, 1, 0, 1, 2'b10, 3'b000, 0);
        for (int k = 0; k < 3; k++) begin
            step(); chk($sformatf("frz_%0d", k), 3'b100);
        end
        drive(1, 1, 1, 1, 2'b10, 3'b000, 0);
        step(); chk("frz_resume1", 3'b110);
        step(); chk("frz_resume2", 3'b100);

        // Asynchronous reset in the middle of an INCR16 held on port 2.
        do_reset();
        drive(1, 0, 1, 1, 2'b10, 3'b111, 0);
        step();
        drive(1, 1, 1, 1, 2'b11, 3'b111, 0);
        step(); step();
        @(posedge HCLK);
        #2 HRESETn = 1'b0;
        #1 chk("rst_async", 3'b101);
        @(negedge HCLK);
        HRESETn = 1'b1;
        drive(0, 1, 1, 1, 2'b11, 3'b111, 0);
        step(); chk("rst_fresh", 3'b110);

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 4) != 0, $urandom_range(0, 5) != 0,
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 9) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
